// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port request/response types, reset constants and arbiter enums.
// Rev 1.0
`default_nettype none

package mem;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [3:0]  be;
  } mem_read_req_t;

  typedef struct packed {
    logic        done;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_read_rsp_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } mem_write_req_t;

  typedef struct packed {
    logic done;
    logic valid;
  } mem_write_rsp_t;

  localparam mem_read_req_t  mem_read_req_rst  = '0;
  localparam mem_read_rsp_t  mem_read_rsp_rst  = '0;
  localparam mem_write_req_t mem_write_req_rst = '0;
  localparam mem_write_rsp_t mem_write_rsp_rst = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_IF = 3'd1,
    RD_DM = 3'd2,
    WR_DM = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    IF    = 2'd0,
    DM_RD = 2'd1,
    DM_WR = 2'd2
  } arb_owner_t;

  // Response returned to the requester when memory never completes.
  function automatic mem_read_rsp_t read_timeout_rsp(input logic [31:0] addr);
    mem_read_rsp_t rsp;
    rsp       = mem_read_rsp_rst;
    rsp.done  = 1'b1;
    rsp.addr  = addr;
    return rsp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick between fetch side and data side with last-grant flop.
// Rev 1.0
`default_nettype none

module mem_arb_rr
  import mem::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_if,
  input  logic i_req_dm,
  output logic o_gnt_if,
  output logic o_gnt_dm
);

  arb_owner_t r_last;
  logic       w_last_dm;

  assign w_last_dm = (r_last != IF);

  // On a tie the side not granted last wins; reset state favours data first.
  always_comb begin
    o_gnt_dm = i_en & i_req_dm & (~i_req_if | ~w_last_dm);
    o_gnt_if = i_en & i_req_if & ~o_gnt_dm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IF;
    end else if (o_gnt_dm) begin
      r_last <= DM_RD;
    end else if (o_gnt_if) begin
      r_last <= IF;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch reads, data reads and data writes onto one shared memory port pair.
// Rev 1.0
`default_nettype none

module mem_port_arbiter
  import mem::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  mem_read_req_t  if_read_req,
  output mem_read_rsp_t  if_read_rsp,
  input  mem_read_req_t  dm_read_req,
  output mem_read_rsp_t  dm_read_rsp,
  input  mem_write_req_t dm_write_req,
  output mem_write_rsp_t dm_write_rsp,
  output mem_read_req_t  mem_read_req,
  input  mem_read_rsp_t  mem_read_rsp,
  output mem_write_req_t mem_write_req,
  input  mem_write_rsp_t mem_write_rsp,
  output logic           busy
);

  localparam logic [16:0] TIMEOUT_VAL = 17'(TIMEOUT_CYCLES);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  arb_owner_t     r_owner;
  logic [15:0]    r_cnt;
  mem_read_req_t  r_mem_rd_req;
  mem_write_req_t r_mem_wr_req;
  mem_read_rsp_t  r_rd_rsp;
  mem_write_rsp_t r_wr_rsp;

  logic w_idle;
  logic w_dm_pend;
  logic w_gnt_if;
  logic w_gnt_dm;
  logic w_cnt_hit;

  assign w_idle    = (r_state == IDLE);
  assign w_dm_pend = dm_write_req.en | dm_read_req.en;
  assign w_cnt_hit = (({1'b0, r_cnt} + 17'd1) == TIMEOUT_VAL);

  mem_arb_rr u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_idle),
    .i_req_if (if_read_req.en),
    .i_req_dm (w_dm_pend),
    .o_gnt_if (w_gnt_if),
    .o_gnt_dm (w_gnt_dm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A done sampled together with the timeout hit still counts as a normal completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_dm) begin
          w_state_nxt = dm_write_req.en ? WR_DM : RD_DM;
        end else if (w_gnt_if) begin
          w_state_nxt = RD_IF;
        end
      end
      RD_IF, RD_DM: begin
        if (mem_read_rsp.done || w_cnt_hit) begin
          w_state_nxt = RESP;
        end
      end
      WR_DM: begin
        if (mem_write_rsp.done || w_cnt_hit) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= IF;
      r_cnt        <= '0;
      r_mem_rd_req <= mem_read_req_rst;
      r_mem_wr_req <= mem_write_req_rst;
      r_rd_rsp     <= mem_read_rsp_rst;
      r_wr_rsp     <= mem_write_rsp_rst;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_gnt_dm && dm_write_req.en) begin
            r_owner      <= DM_WR;
            r_mem_wr_req <= dm_write_req;
          end else if (w_gnt_dm) begin
            r_owner      <= DM_RD;
            r_mem_rd_req <= dm_read_req;
          end else if (w_gnt_if) begin
            r_owner      <= IF;
            r_mem_rd_req <= if_read_req;
          end
        end
        RD_IF, RD_DM: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem_read_rsp.done) begin
            r_rd_rsp     <= mem_read_rsp;
            r_mem_rd_req <= mem_read_req_rst;
          end else if (w_cnt_hit) begin
            r_rd_rsp     <= read_timeout_rsp(r_mem_rd_req.addr);
            r_mem_rd_req <= mem_read_req_rst;
          end
        end
        WR_DM: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem_write_rsp.done) begin
            r_wr_rsp     <= mem_write_rsp;
            r_mem_wr_req <= mem_write_req_rst;
          end else if (w_cnt_hit) begin
            r_wr_rsp       <= mem_write_rsp_rst;
            r_wr_rsp.done  <= 1'b1;
            r_mem_wr_req   <= mem_write_req_rst;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_read_req  = r_mem_rd_req;
  assign mem_write_req = r_mem_wr_req;
  assign busy          = ~w_idle;

  assign if_read_rsp  = (r_state == RESP && r_owner == IF)    ? r_rd_rsp : mem_read_rsp_rst;
  assign dm_read_rsp  = (r_state == RESP && r_owner == DM_RD) ? r_rd_rsp : mem_read_rsp_rst;
  assign dm_write_rsp = (r_state == RESP && r_owner == DM_WR) ? r_wr_rsp : mem_write_rsp_rst;

endmodule

`default_nettype wire
